conv3x3_ic_accum_sched: RTL and testbench

- Sequences a conv3x3 vector MAC (one window × OC_PAR weight sets per beat, 1-cycle registered latency, valid/ready on both sides) across input channels and output pixels.
- Forwards per-channel beats from the line-buffer/weight fetch stage into the MAC and accumulates the MAC's per-channel partial sums over cfg_num_ic channels, seeded with bias.
- Emits one OC_PAR-lane accumulator vector per output pixel to the requant stage.
- Runs one job of cfg_num_pix pixels per start pulse.

---
 rtl/conv3x3_ic_accum_sched_if.sv | 53 +++++
 rtl/conv3x3_ic_accum_sched.sv | 152 +++++++++++++++
 tb/tb_conv3x3_ic_accum_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_ic_accum_sched_if.sv
// Handshake bundle between the conv3x3 channel/pixel scheduler, its upstream fetch stage,
// the vector MAC and the requant stage.
interface conv3x3_ic_accum_sched_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned OC_PAR = 4
);
    localparam int unsigned WIN_W = 9 * DATA_W;
    localparam int unsigned WGT_W = OC_PAR * WIN_W;
    localparam int unsigned VEC_W = OC_PAR * ACC_W;

    logic             src_valid;
    logic             src_ready;
    logic [WIN_W-1:0] src_window;
    logic [WGT_W-1:0] src_weights;

    logic             mac_in_valid;
    logic             mac_in_ready;
    logic [WIN_W-1:0] mac_window;
    logic [WGT_W-1:0] mac_weights;

    logic             mac_out_valid;
    logic             mac_out_ready;
    logic [VEC_W-1:0] mac_out_acc_vec;

    logic             res_valid;
    logic             res_ready;
    logic [VEC_W-1:0] res_acc_vec;

    // Scheduler side
    modport master (
        input  src_valid, src_window, src_weights,
        input  mac_in_ready,
        input  mac_out_valid, mac_out_acc_vec,
        input  res_ready,
        output src_ready,
        output mac_in_valid, mac_window, mac_weights,
        output mac_out_ready,
        output res_valid, res_acc_vec
    );

    // Fetch stage, MAC and requant side
    modport slave (
        output src_valid, src_window, src_weights,
        output mac_in_ready,
        output mac_out_valid, mac_out_acc_vec,
        output res_ready,
        input  src_ready,
        input  mac_in_valid, mac_window, mac_weights,
        input  mac_out_ready,
        input  res_valid, res_acc_vec
    );
endinterface

// File: rtl/conv3x3_ic_accum_sched.sv
// Schedules conv3x3 MAC beats over input channels and pixels, accumulating per-channel
// partial sums (seeded with bias) into one OC_PAR-lane result per output pixel.
module conv3x3_ic_accum_sched #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned OC_PAR = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        cfg_num_ic,
    input  logic [CNT_W-1:0]        cfg_num_pix,
    input  logic [OC_PAR*ACC_W-1:0] bias_vec,
    output logic                    busy,
    output logic                    done,
    conv3x3_ic_accum_sched_if.master bus
);
    localparam int unsigned VEC_W = OC_PAR * ACC_W;
    localparam int unsigned TOT_W = 2 * CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   num_ic_q;
    logic [CNT_W-1:0]   num_pix_q;
    logic [TOT_W-1:0]   total_q;
    logic [TOT_W-1:0]   issued_q;
    logic [CNT_W-1:0]   ic_cnt_q;
    logic [CNT_W-1:0]   pix_cnt_q;
    logic [VEC_W-1:0]   acc_q;
    logic               res_valid_q;
    logic [VEC_W-1:0]   res_acc_q;

    logic               run_c;
    logic               job_start_c;
    logic               issue_en_c;
    logic               in_hs_c;
    logic               part_hs_c;
    logic               res_hs_c;
    logic               last_ic_c;
    logic               last_pix_c;
    logic [CNT_W-1:0]   num_ic_eff_c;
    logic [VEC_W-1:0]   acc_sum_c;

    assign run_c        = (state_q == ST_RUN);
    assign job_start_c  = (state_q == ST_IDLE) && start;
    assign num_ic_eff_c = (cfg_num_ic == '0) ? CNT_W'(1) : cfg_num_ic;

    // Issue side: pure pass-through gated by the remaining beat budget of the job
    assign issue_en_c        = run_c && (issued_q < total_q);
    assign bus.mac_in_valid  = bus.src_valid & issue_en_c;
    assign bus.src_ready     = bus.mac_in_ready & issue_en_c;
    assign bus.mac_window    = bus.src_window;
    assign bus.mac_weights   = bus.src_weights;
    assign in_hs_c           = bus.mac_in_valid & bus.mac_in_ready;

    // Partials stall while a finished pixel waits, so partial and result handshakes never overlap
    assign bus.mac_out_ready = run_c & ~res_valid_q;
    assign part_hs_c         = bus.mac_out_valid & bus.mac_out_ready;
    assign res_hs_c          = res_valid_q & bus.res_ready;

    assign last_ic_c  = (ic_cnt_q == (num_ic_q - CNT_W'(1)));
    assign last_pix_c = (pix_cnt_q == num_pix_q);

    assign bus.res_valid   = res_valid_q;
    assign bus.res_acc_vec = res_acc_q;
    assign busy            = run_c;
    assign done            = (state_q == ST_FIN);

    // Per-lane wrapping add; the first channel of a pixel starts from bias
    always_comb begin
        acc_sum_c = '0;
        for (int unsigned l = 0; l < OC_PAR; l++) begin
            acc_sum_c[l*ACC_W +: ACC_W] =
                ((ic_cnt_q == '0) ? bias_vec[l*ACC_W +: ACC_W] : acc_q[l*ACC_W +: ACC_W])
                + bus.mac_out_acc_vec[l*ACC_W +: ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_num_pix == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (res_hs_c && last_pix_c) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Job configuration, counters and accumulator datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_ic_q    <= '0;
            num_pix_q   <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            ic_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_acc_q   <= '0;
        end else begin
            if (job_start_c) begin
                num_ic_q  <= num_ic_eff_c;
                num_pix_q <= cfg_num_pix;
                total_q   <= TOT_W'(num_ic_eff_c) * TOT_W'(cfg_num_pix);
                issued_q  <= '0;
                ic_cnt_q  <= '0;
                pix_cnt_q <= '0;
            end
            if (in_hs_c) begin
                issued_q <= issued_q + TOT_W'(1);
            end
            if (part_hs_c) begin
                acc_q <= acc_sum_c;
                if (last_ic_c) begin
                    ic_cnt_q    <= '0;
                    pix_cnt_q   <= pix_cnt_q + CNT_W'(1);
                    res_valid_q <= 1'b1;
                    res_acc_q   <= acc_sum_c;
                end else begin
                    ic_cnt_q <= ic_cnt_q + CNT_W'(1);
                end
            end
            if (res_hs_c) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_ic_accum_sched.sv
// Directed bench for conv3x3_ic_accum_sched: the bench plays fetch stage, MAC and requant.
module tb_conv3x3_ic_accum_sched;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned OC_PAR = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned VEC_W  = OC_PAR * ACC_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [CNT_W-1:0]   cfg_num_ic;
    logic [CNT_W-1:0]   cfg_num_pix;
    logic [VEC_W-1:0]   bias_vec;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;

    conv3x3_ic_accum_sched_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OC_PAR(OC_PAR)) bus ();

    conv3x3_ic_accum_sched #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .OC_PAR(OC_PAR), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_num_ic (cfg_num_ic),
        .cfg_num_pix(cfg_num_pix),
        .bias_vec   (bias_vec),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] mkvec(input logic [ACC_W-1:0] l0, input logic [ACC_W-1:0] l1,
                                               input logic [ACC_W-1:0] l2, input logic [ACC_W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Called and returning on a negedge; start is seen by exactly one posedge
    task automatic start_job(input int ic, input int pix, input logic [VEC_W-1:0] b);
        cfg_num_ic  = CNT_W'(ic);
        cfg_num_pix = CNT_W'(pix);
        bias_vec    = b;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic push_partial(input logic [VEC_W-1:0] v, input string tag);
        int n = 0;
        bus.mac_out_valid   = 1'b1;
        bus.mac_out_acc_vec = v;
        #1;
        while (!bus.mac_out_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.mac_out_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s partial_accept got=%b want=1", tag, bus.mac_out_ready);
        end
        @(negedge clk);
        bus.mac_out_valid = 1'b0;
    endtask

    task automatic take_res(output logic [VEC_W-1:0] v, input string tag);
        int n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s res_wait got=%b want=1", tag, bus.res_valid);
        end
        v = bus.res_acc_vec;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.src_valid    = 1'b1;
        bus.mac_in_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, done, bus.res_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {busy, done, bus.res_valid});
        end
        checks++;
        if (bus.res_acc_vec !== '0) begin
            failures++;
            $display("FAIL reset_res_acc got=%h want=0", bus.res_acc_vec);
        end
        checks++;
        if ({bus.src_ready, bus.mac_in_valid, bus.mac_out_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle_ready got=%b want=000", {bus.src_ready, bus.mac_in_valid, bus.mac_out_ready});
        end
        bus.src_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_accum_basic();
        logic [VEC_W-1:0] r;
        start_job(3, 1, mkvec(32'd10, 32'd100, 32'd0, 32'hFFFF_FFFB));
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b want=1", busy);
        end
        push_partial(mkvec(32'd5, 32'd1, 32'd0, 32'd0), "basic_p0");
        push_partial(mkvec(32'hFFFF_FFFE, 32'd2, 32'd0, 32'd0), "basic_p1");
        push_partial(mkvec(32'd7, 32'd3, 32'd0, 32'd0), "basic_p2");
        checks++;
        if (bus.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency got=%b want=1", bus.res_valid);
        end
        take_res(r, "basic");
        checks++;
        if (r !== mkvec(32'd20, 32'd106, 32'd0, 32'hFFFF_FFFB)) begin
            failures++;
            $display("FAIL basic_result got=%h want=%h", r, mkvec(32'd20, 32'd106, 32'd0, 32'hFFFF_FFFB));
        end
        checks++;
        if ({done, busy, bus.res_valid} !== 3'b100) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b want=100", {done, busy, bus.res_valid});
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL basic_done_end got=%b want=00", {done, busy});
        end
    endtask

    task automatic test_issue_pixels();
        logic [VEC_W-1:0] r;
        int accepted = 0;
        start_job(1, 4, '0);
        bus.src_window   = {9{8'hA5}};
        bus.src_weights  = {36{8'h3C}};
        bus.src_valid    = 1'b1;
        bus.mac_in_ready = 1'b0;
        #1;
        checks++;
        if ({bus.mac_in_valid, bus.src_ready} !== 2'b10) begin
            failures++;
            $display("FAIL issue_stall got=%b want=10", {bus.mac_in_valid, bus.src_ready});
        end
        checks++;
        if (bus.mac_window !== {9{8'hA5}} || bus.mac_weights !== {36{8'h3C}}) begin
            failures++;
            $display("FAIL issue_passthru got=%h want=%h", bus.mac_window, {9{8'hA5}});
        end
        bus.mac_in_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (bus.src_ready) accepted++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (accepted != 4) begin
            failures++;
            $display("FAIL issue_count got=%0d want=4", accepted);
        end
        checks++;
        if ({bus.src_ready, bus.mac_in_valid} !== 2'b00) begin
            failures++;
            $display("FAIL issue_fifth_beat got=%b want=00", {bus.src_ready, bus.mac_in_valid});
        end
        bus.src_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            push_partial(mkvec(32'(p), 32'(p), 32'(p), 32'(p)), "pix");
            take_res(r, "pix");
            checks++;
            if (r !== mkvec(32'(p), 32'(p), 32'(p), 32'(p))) begin
                failures++;
                $display("FAIL pix_result p=%0d got=%h want=%h", p, r, mkvec(32'(p), 32'(p), 32'(p), 32'(p)));
            end
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL pix_done got=%b want=1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [VEC_W-1:0] r;
        start_job(1, 1, mkvec(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0));
        push_partial(mkvec(32'd1, 32'd1, 32'hFFFF_FFFF, 32'd0), "wrap");
        take_res(r, "wrap");
        checks++;
        if (r !== mkvec(32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd0)) begin
            failures++;
            $display("FAIL wrap_result got=%h want=%h", r, mkvec(32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd0));
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [VEC_W-1:0] r;
        logic [VEC_W-1:0] exp0;
        int bad = 0;
        exp0 = mkvec(32'd11, 32'd12, 32'd13, 32'd14);
        start_job(1, 2, mkvec(32'd1, 32'd2, 32'd3, 32'd4));
        push_partial(mkvec(32'd10, 32'd10, 32'd10, 32'd10), "bp_p0");
        bus.mac_out_valid   = 1'b1;
        bus.mac_out_acc_vec = mkvec(32'd20, 32'd20, 32'd20, 32'd20);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.res_valid !== 1'b1 || bus.res_acc_vec !== exp0 || bus.mac_out_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d want=0 res=%h", bad, bus.res_acc_vec);
        end
        take_res(r, "bp0");
        checks++;
        if (r !== exp0) begin
            failures++;
            $display("FAIL bp_result0 got=%h want=%h", r, exp0);
        end
        push_partial(mkvec(32'd20, 32'd20, 32'd20, 32'd20), "bp_p1");
        take_res(r, "bp1");
        checks++;
        if (r !== mkvec(32'd21, 32'd22, 32'd23, 32'd24)) begin
            failures++;
            $display("FAIL bp_result1 got=%h want=%h", r, mkvec(32'd21, 32'd22, 32'd23, 32'd24));
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL bp_done got=%b want=1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_cfg();
        logic [VEC_W-1:0] r;
        bus.src_valid    = 1'b1;
        bus.mac_in_ready = 1'b1;
        start_job(1, 0, '0);
        #1;
        checks++;
        if ({done, busy, bus.res_valid, bus.src_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL zero_pix got=%b want=1000", {done, busy, bus.res_valid, bus.src_ready});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_pix_done_end got=%b want=0", done);
        end
        bus.src_valid = 1'b0;
        start_job(0, 1, mkvec(32'd5, 32'd0, 32'd0, 32'd0));
        push_partial(mkvec(32'd7, 32'd1, 32'd2, 32'd3), "zero_ic");
        checks++;
        if (bus.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_ic_latency got=%b want=1", bus.res_valid);
        end
        take_res(r, "zero_ic");
        checks++;
        if (r !== mkvec(32'd12, 32'd1, 32'd2, 32'd3)) begin
            failures++;
            $display("FAIL zero_ic_result got=%h want=%h", r, mkvec(32'd12, 32'd1, 32'd2, 32'd3));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [VEC_W-1:0] r;
        start_job(4, 1, mkvec(32'd1, 32'd1, 32'd1, 32'd1));
        push_partial(mkvec(32'd50, 32'd50, 32'd50, 32'd50), "rst_p0");
        push_partial(mkvec(32'd60, 32'd60, 32'd60, 32'd60), "rst_p1");
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus.res_valid, bus.mac_out_ready} !== 4'b0000 || bus.res_acc_vec !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%b res=%h want=0000 res=0",
                     {busy, done, bus.res_valid, bus.mac_out_ready}, bus.res_acc_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_job(2, 1, mkvec(32'd3, 32'd3, 32'd3, 32'd3));
        push_partial(mkvec(32'd4, 32'd4, 32'd4, 32'd4), "post_rst_p0");
        push_partial(mkvec(32'd5, 32'd5, 32'd5, 32'd5), "post_rst_p1");
        take_res(r, "post_rst");
        checks++;
        if (r !== mkvec(32'd12, 32'd12, 32'd12, 32'd12)) begin
            failures++;
            $display("FAIL post_reset_result got=%h want=%h", r, mkvec(32'd12, 32'd12, 32'd12, 32'd12));
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_done got=%b want=1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n               = 1'b0;
        start               = 1'b0;
        cfg_num_ic          = '0;
        cfg_num_pix         = '0;
        bias_vec            = '0;
        bus.src_valid       = 1'b0;
        bus.src_window      = '0;
        bus.src_weights     = '0;
        bus.mac_in_ready    = 1'b0;
        bus.mac_out_valid   = 1'b0;
        bus.mac_out_acc_vec = '0;
        bus.res_ready       = 1'b0;

        test_reset();
        test_accum_basic();
        test_issue_pixels();
        test_wrap();
        test_backpressure();
        test_zero_cfg();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
